mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 77 +++++++
 tb/tb_mem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and downstream memory-port signals around the arbiter.
// slave is the arbiter's view; master is the CPU/memory side that surrounds it.
interface mem_port_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ok;
  logic [63:0] m_rdata;
  logic        busy;
  logic        err_timeout;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ok, m_rdata,
    output i_data_ok, i_data, d_data_ok, d_rdata,
    output m_valid, m_addr, m_size, m_strobe, m_wdata, busy, err_timeout
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ok, m_rdata,
    input  i_data_ok, i_data, d_data_ok, d_rdata,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata, busy, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data access,
// one transaction at a time, with a sticky watchdog on stuck transactions.
module mem_port_arbiter #(
  parameter bit          DPRIO   = 1'b1,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

  state_t        state;
  logic          last_d;
  logic [CW-1:0] wdog;
  logic          grant_d;

  // A lone request always wins; on a tie the pointer only matters without DPRIO.
  assign grant_d = bus.d_valid && (!bus.i_valid || DPRIO || !last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_d          <= 1'b0;
      wdog            <= '0;
      bus.m_valid     <= 1'b0;
      bus.m_addr      <= '0;
      bus.m_size      <= '0;
      bus.m_strobe    <= '0;
      bus.m_wdata     <= '0;
      bus.busy        <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid || bus.d_valid) begin
            state       <= grant_d ? DBUSY : IBUSY;
            last_d      <= grant_d;
            wdog        <= '0;
            bus.m_valid <= 1'b1;
            bus.busy    <= 1'b1;
            if (grant_d) begin
              bus.m_addr   <= bus.d_addr;
              bus.m_size   <= bus.d_size;
              bus.m_strobe <= bus.d_strobe;
              bus.m_wdata  <= bus.d_wdata;
            end else begin
              bus.m_addr   <= bus.i_addr;
              bus.m_size   <= 3'b010;
              bus.m_strobe <= 8'h00;
              bus.m_wdata  <= 64'h0;
            end
          end
        end
        default: begin
          if (bus.m_ok) begin
            state       <= IDLE;
            bus.m_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (TIMEOUT != 0 && wdog != TMAX) begin
            // The flag is only a report; the transaction keeps waiting for m_ok.
            wdog <= wdog + 1'b1;
            if (wdog + 1'b1 == TMAX) bus.err_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.i_data_ok = (state == IBUSY) && bus.m_ok;
  assign bus.d_data_ok = (state == DBUSY) && bus.m_ok;
  assign bus.i_data    = bus.i_data_ok ? (bus.m_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0]) : 32'h0;
  assign bus.d_rdata   = bus.d_data_ok ? bus.m_rdata : 64'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (DPRIO=1, DPRIO=0, TIMEOUT=8)
// share stimulus; a vector table plus hand sequences check each against hand values.
module tb_mem_port_arbiter;
  logic clk, rst;
  logic iv, dv, mok;
  logic [63:0] ia, da, dw, mrd;
  logic [2:0] ds;
  logic [7:0] dst;

  logic [2:0] mv, busy, iok, dok, err;
  logic [2:0][63:0] maddr, mwdata, drdata;
  logic [2:0][2:0] msize;
  logic [2:0][7:0] mstrb;
  logic [2:0][31:0] idata;

  for (genvar k = 0; k < 3; k++) begin : g
    mem_port_arbiter_if bus ();
    assign bus.i_valid = iv;
    assign bus.i_addr = ia;
    assign bus.d_valid = dv;
    assign bus.d_addr = da;
    assign bus.d_size = ds;
    assign bus.d_strobe = dst;
    assign bus.d_wdata = dw;
    assign bus.m_ok = mok;
    assign bus.m_rdata = mrd;
    mem_port_arbiter #(.DPRIO(k != 1), .TIMEOUT((k == 2) ? 8 : 1023)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign mv[k] = bus.m_valid;
    assign busy[k] = bus.busy;
    assign iok[k] = bus.i_data_ok;
    assign dok[k] = bus.d_data_ok;
    assign err[k] = bus.err_timeout;
    assign maddr[k] = bus.m_addr;
    assign mwdata[k] = bus.m_wdata;
    assign drdata[k] = bus.d_rdata;
    assign msize[k] = bus.m_size;
    assign mstrb[k] = bus.m_strobe;
    assign idata[k] = bus.i_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [63:0] ia; logic dv; logic [63:0] da; logic [2:0] ds; logic [7:0] dst;
    logic [63:0] dw; logic mok; logic [63:0] mrd;
    logic xmv; logic [63:0] xma; logic [2:0] xms; logic [7:0] xmst; logic [63:0] xmw;
    logic xbusy; logic xiok; logic [31:0] xid; logic xdok; logic [63:0] xdrd;
  } vec_t;

  localparam logic [63:0] Z = 64'h0;
  localparam logic [63:0] IA1 = 64'h0000_0000_8000_0004;
  localparam logic [63:0] IA2 = 64'h0000_0000_8000_0008;
  localparam logic [63:0] DA = 64'h0000_0000_8000_1000;
  localparam logic [63:0] DW = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] RD1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RD2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] RD3 = 64'hAAAA_BBBB_CCCC_DDDD;

  vec_t vecs[16];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic cond, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (cond) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // lone fetch: m_ok three cycles after m_valid, upper word selected by addr[2]
    vecs[0]  = '{1'b0, Z, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, Z,   1'b0, Z, 3'd0, 8'h00, Z,  1'b0, 1'b0, 32'h0, 1'b0, Z};
    vecs[1]  = '{1'b1, IA1, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, Z, 1'b0, Z, 3'd0, 8'h00, Z,  1'b0, 1'b0, 32'h0, 1'b0, Z};
    vecs[2]  = '{1'b1, IA1, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, Z, 1'b1, IA1, 3'd2, 8'h00, Z, 1'b1, 1'b0, 32'h0, 1'b0, Z};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1'b1, IA1, 1'b0, Z, 3'd0, 8'h00, Z, 1'b1, RD1, 1'b1, IA1, 3'd2, 8'h00, Z, 1'b1, 1'b1, 32'h1111_2222, 1'b0, Z};
    vecs[6]  = vecs[0];
    // tie with DPRIO=1: data first, d_addr change while busy ignored, idle gap, then fetch
    vecs[7]  = '{1'b1, IA2, 1'b1, DA, 3'd3, 8'hFF, DW, 1'b0, Z, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, 1'b0, 32'h0, 1'b0, Z};
    vecs[8]  = '{1'b1, IA2, 1'b1, DA, 3'd3, 8'hFF, DW, 1'b0, Z, 1'b1, DA, 3'd3, 8'hFF, DW, 1'b1, 1'b0, 32'h0, 1'b0, Z};
    vecs[9]  = '{1'b1, IA2, 1'b1, Z, 3'd3, 8'hFF, DW, 1'b0, Z,  1'b1, DA, 3'd3, 8'hFF, DW, 1'b1, 1'b0, 32'h0, 1'b0, Z};
    vecs[10] = '{1'b1, IA2, 1'b1, Z, 3'd3, 8'hFF, DW, 1'b1, RD2, 1'b1, DA, 3'd3, 8'hFF, DW, 1'b1, 1'b0, 32'h0, 1'b1, RD2};
    vecs[11] = '{1'b1, IA2, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, Z, 1'b0, Z, 3'd0, 8'h00, Z,  1'b0, 1'b0, 32'h0, 1'b0, Z};
    vecs[12] = '{1'b1, IA2, 1'b0, Z, 3'd0, 8'h00, Z, 1'b0, Z, 1'b1, IA2, 3'd2, 8'h00, Z, 1'b1, 1'b0, 32'h0, 1'b0, Z};
    vecs[13] = '{1'b1, IA2, 1'b0, Z, 3'd0, 8'h00, Z, 1'b1, RD3, 1'b1, IA2, 3'd2, 8'h00, Z, 1'b1, 1'b1, 32'hCCCC_DDDD, 1'b0, Z};
    // spurious m_ok while idle
    vecs[14] = '{1'b0, Z, 1'b0, Z, 3'd0, 8'h00, Z, 1'b1, RD3,  1'b0, Z, 3'd0, 8'h00, Z,  1'b0, 1'b0, 32'h0, 1'b0, Z};
    vecs[15] = vecs[0];

    rst = 1'b1; iv = 1'b0; dv = 1'b0; mok = 1'b0;
    ia = Z; da = Z; dw = Z; mrd = Z; ds = 3'd0; dst = 8'h00;
    #3;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_dut%0d", k),
          mv[k] == 1'b0 && busy[k] == 1'b0 && err[k] == 1'b0 && iok[k] == 1'b0 && dok[k] == 1'b0 &&
          maddr[k] == Z && mwdata[k] == Z && msize[k] == 3'd0 && mstrb[k] == 8'h00 &&
          idata[k] == 32'h0 && drdata[k] == Z,
          {59'h0, mv[k], busy[k], err[k], iok[k], dok[k]} | maddr[k], Z);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int n = 0; n < 16; n++) begin
      iv = vecs[n].iv; ia = vecs[n].ia; dv = vecs[n].dv; da = vecs[n].da; ds = vecs[n].ds;
      dst = vecs[n].dst; dw = vecs[n].dw; mok = vecs[n].mok; mrd = vecs[n].mrd;
      @(negedge clk);
      checks++;
      if (mv[0] == vecs[n].xmv && busy[0] == vecs[n].xbusy && iok[0] == vecs[n].xiok &&
          dok[0] == vecs[n].xdok && idata[0] == vecs[n].xid && drdata[0] == vecs[n].xdrd &&
          (!vecs[n].xmv || (maddr[0] == vecs[n].xma && msize[0] == vecs[n].xms &&
                            mstrb[0] == vecs[n].xmst && mwdata[0] == vecs[n].xmw)))
        passes++;
      else
        $display("FAIL row%0d: got mv=%b busy=%b iok=%b dok=%b addr=%h size=%0d strb=%h wdata=%h idata=%h drdata=%h; expected mv=%b busy=%b iok=%b dok=%b addr=%h size=%0d strb=%h wdata=%h idata=%h drdata=%h",
                 n, mv[0], busy[0], iok[0], dok[0], maddr[0], msize[0], mstrb[0], mwdata[0], idata[0], drdata[0],
                 vecs[n].xmv, vecs[n].xbusy, vecs[n].xiok, vecs[n].xdok, vecs[n].xma, vecs[n].xms,
                 vecs[n].xmst, vecs[n].xmw, vecs[n].xid, vecs[n].xdrd);
      @(posedge clk); #1;
    end

    // round-robin (DPRIO=0 instance): last grant was a fetch, so order is D, I, D, I
    iv = 1'b1; ia = 64'h100; dv = 1'b1; da = 64'h200; ds = 3'd3; dst = 8'h00; mok = 1'b0; mrd = RD2;
    for (int t = 0; t < 4; t++) begin
      automatic logic exp_d = (t % 2 == 0);
      automatic int waited = 0;
      @(negedge clk);
      while (!mv[1] && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      chk($sformatf("rr_grant%0d", t), mv[1] && maddr[1] == (exp_d ? 64'h200 : 64'h100),
          maddr[1], exp_d ? 64'h200 : 64'h100);
      mok = 1'b1;
      #1;
      chk($sformatf("rr_data_ok%0d", t), (exp_d ? dok[1] : iok[1]) && !(exp_d ? iok[1] : dok[1]),
          {62'h0, dok[1], iok[1]}, exp_d ? 64'h2 : 64'h1);
      @(posedge clk); #1;
      mok = 1'b0;
    end
    iv = 1'b0; dv = 1'b0;

    // watchdog on the TIMEOUT=8 instance, then asynchronous reset mid-cycle
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("wd_clear", err[2] == 1'b0 && busy[2] == 1'b0, {62'h0, err[2], busy[2]}, Z);
    iv = 1'b1; ia = 64'h300;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    chk("wd_7_cycles", err[2] == 1'b0 && mv[2] == 1'b1, {62'h0, err[2], mv[2]}, 64'h1);
    @(posedge clk); #1;
    chk("wd_8_cycles", err[2] == 1'b1 && mv[2] == 1'b1 && busy[2] == 1'b1,
        {61'h0, err[2], mv[2], busy[2]}, 64'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", mv[2] == 1'b0 && busy[2] == 1'b0 && err[2] == 1'b0 && iok[2] == 1'b0,
        {60'h0, err[2], mv[2], busy[2], iok[2]}, Z);
    iv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
